// File: rtl/bcd_converter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_converter: sequential shift-and-add-3 binary to BCD, one bit per clock. |
// | Optional feature macro: BCD_AUTO_START_EN. Revision 1.0                     |
// +----------------------------------------------------------------------------+
module bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam longint unsigned C_MAX_BIN   = (64'd1 << WIDTH) - 64'd1;
  localparam longint unsigned C_DEC_RANGE = 64'd10 ** DIGITS;

  if (C_DEC_RANGE <= C_MAX_BIN) begin : g_digits_check
    $error("bcd_converter: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     scratch_adj;
  logic [BW-1:0]     scratch_shifted;
  logic              accept;

`ifdef BCD_AUTO_START_EN
  logic [WIDTH-1:0]  last_bin_q, last_bin_d;
  logic              unused_start;
  assign unused_start = start;
  assign accept = (state_q != S_SHIFT) && (bin_in != last_bin_q);
`else
  assign accept = (state_q != S_SHIFT) && start;
`endif

  always_comb begin
    scratch_adj = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
  end

  assign scratch_shifted = {scratch_adj[BW-2:0], shift_q[WIDTH-1]};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
`ifdef BCD_AUTO_START_EN
    last_bin_d = last_bin_q;
`endif
    case (state_q)
      S_SHIFT: begin
        scratch_d = scratch_shifted;
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CW'(1);
        busy_d    = 1'b1;
        // Publish on the final shift so done and the result share a cycle.
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = scratch_shifted;
        end
      end
      default: begin
        if (accept) begin
          state_d   = S_SHIFT;
          shift_d   = bin_in;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          busy_d    = 1'b1;
`ifdef BCD_AUTO_START_EN
          last_bin_d = bin_in;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
`ifdef BCD_AUTO_START_EN
      last_bin_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
`ifdef BCD_AUTO_START_EN
      last_bin_q <= last_bin_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule
`default_nettype wire
